seq_detector_n: RTL and testbench

Parametrised Moore sequence detector: watches a serial bit stream `D` and pulses `out` one cycle after the last bit of an N-bit pattern has been sampled. It generalises the team's fixed 6-bit "100110" detector with a configurable pattern and length, a sample-enable qualifier, and a runtime overlapping/non-overlapping mode select. It also keeps a saturating match counter. It sits on a serial input lane after the bit-sync logic and feeds the frame-alignment and statistics blocks.

---
 rtl/seq_detector_n_if.sv | 38 +++
 rtl/seq_detector_n.sv | 98 +++++++++
 tb/tb_seq_detector_n.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seq_detector_n_if.sv
// Serial-lane bundle for seq_detector_n: sample qualifier, data bit, mode, match outputs.
// Latency: none (wires only).
// Backpressure: none; the detector consumes a bit on every edge where en=1.
//
// Signals: en/D/ovl (to detector), out/match_cnt (from detector),
//          pat_we/pat_in (to detector, only when SEQDET_PROG_EN is defined).
interface seq_detector_n_if #(
   parameter int N     = 6,
   parameter int CNT_W = 8
);
   logic             en;
   logic             D;
   logic             ovl;
   logic             out;
   logic [CNT_W-1:0] match_cnt;
`ifdef SEQDET_PROG_EN
   logic             pat_we;
   logic [N-1:0]     pat_in;
`endif

   // Source side of the serial lane (bit-sync logic / bench).
   modport master (
      output en, D, ovl,
`ifdef SEQDET_PROG_EN
      output pat_we, pat_in,
`endif
      input  out, match_cnt
   );

   // Detector side.
   modport slave (
      input  en, D, ovl,
`ifdef SEQDET_PROG_EN
      input  pat_we, pat_in,
`endif
      output out, match_cnt
   );
endinterface

// File: rtl/seq_detector_n.sv
// Parametrised Moore detector of an N-bit serial pattern with a saturating match counter.
// Latency: out is high the cycle after the edge that samples the last pattern bit.
// Backpressure: none; bits are taken only on edges with en=1, en=0 simply holds state.
//
// Ports: clk, rst (synchronous, active-high), bus (seq_detector_n_if.slave):
//    en, D, ovl in; out, match_cnt out; pat_we, pat_in in when SEQDET_PROG_EN is defined.
// Optional feature macro: SEQDET_PROG_EN (runtime-writable pattern). Without it the
// pattern is the constant PATTERN.
module seq_detector_n #(
   parameter int           N       = 6,
   parameter logic [N-1:0] PATTERN = 6'b100110,
   parameter int           CNT_W   = 8
) (
   input logic           clk,
   input logic           rst,
   seq_detector_n_if.slave bus
);

   localparam int              FILL_W    = $clog2(N + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

   logic [N-1:0]      hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              out_q,  out_d;
   logic [CNT_W-1:0]  cnt_q,  cnt_d;
   logic [N-1:0]      pat_act;

   logic [N-1:0]      nh;
   logic [FILL_W-1:0] nf;
   logic              match_hit;

`ifdef SEQDET_PROG_EN
   logic [N-1:0]      pat_q, pat_d;
   assign pat_act = pat_q;
`else
   assign pat_act = PATTERN;
`endif

   // Candidate next history/fill if this edge is a qualified sample.
   always_comb begin
      nh        = {hist_q[N-2:0], bus.D};
      nf        = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
      match_hit = (nf == FILL_FULL) && (nh == pat_act);
   end

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      out_d  = 1'b0;
      cnt_d  = cnt_q;
`ifdef SEQDET_PROG_EN
      pat_d  = pat_q;
      if (bus.pat_we) begin
         // A new pattern restarts detection; any coincident sample is dropped.
         pat_d  = bus.pat_in;
         fill_d = '0;
      end else
`endif
      if (bus.en) begin
         hist_d = nh;
         if (match_hit) begin
            out_d = 1'b1;
            if (!(&cnt_q)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // Non-overlapping mode forgets the matched bits so the next match
            // needs N fresh samples.
            fill_d = bus.ovl ? nf : '0;
         end else begin
            fill_d = nf;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= '0;
         fill_q <= '0;
         out_q  <= 1'b0;
         cnt_q  <= '0;
`ifdef SEQDET_PROG_EN
         pat_q  <= PATTERN;
`endif
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         out_q  <= out_d;
         cnt_q  <= cnt_d;
`ifdef SEQDET_PROG_EN
         pat_q  <= pat_d;
`endif
      end
   end

   assign bus.out       = out_q;
   assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_n.sv
// Directed bench for seq_detector_n: a default instance (CNT_W=8) and a narrow-counter
// instance (CNT_W=2) receive identical serial stimulus; expected values are hand-derived.
// Define SEQDET_PROG_EN to also cover the programmable pattern.
module tb_seq_detector_n;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   seq_detector_n_if #(.N(6), .CNT_W(8)) a ();
   seq_detector_n_if #(.N(6), .CNT_W(2)) b ();

   seq_detector_n #(.N(6), .PATTERN(6'b100110), .CNT_W(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (a)
   );

   seq_detector_n #(.N(6), .PATTERN(6'b100110), .CNT_W(2)) u_sat (
      .clk (clk),
      .rst (rst),
      .bus (b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive one edge on both instances, then check out of the default instance.
   task automatic step(input logic e, input logic d, input logic o, input logic exp_out,
                       input string tag);
      a.en = e; a.D = d; a.ovl = o;
      b.en = e; b.D = d; b.ovl = o;
      @(posedge clk);
      #1;
      chk_bit(tag, a.out, exp_out);
   endtask

   task automatic do_reset();
      a.en = 1'b0; b.en = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Feed a 6-bit word MSB first with en=1; expected out per bit given as a mask.
   task automatic word(input logic [5:0] w, input logic o, input logic [5:0] exp_mask,
                       input string tag);
      logic [5:0] wv;
      logic [5:0] mv;
      wv = w;
      mv = exp_mask;
      for (int i = 5; i >= 0; i--) begin
         step(1'b1, wv[i], o, mv[i], tag);
      end
   endtask

   initial begin
      logic [3:0] tail;
      logic [3:0] tail_exp;
      rst = 1'b1;
      a.en = 1'b0; a.D = 1'b0; a.ovl = 1'b0;
      b.en = 1'b0; b.D = 1'b0; b.ovl = 1'b0;
`ifdef SEQDET_PROG_EN
      a.pat_we = 1'b0; a.pat_in = '0;
      b.pat_we = 1'b0; b.pat_in = '0;
`endif
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_bit("reset_out",     a.out, 1'b0);
      chk_cnt("reset_cnt",     a.match_cnt, 8'd0);
      chk_bit("reset_out_sat", b.out, 1'b0);
      chk_cnt("reset_cnt_sat", {6'd0, b.match_cnt}, 8'd0);
      rst = 1'b0;

      // Basic match: single pulse after the 6th bit.
      word(6'b100110, 1'b1, 6'b000001, "basic_out");
      chk_cnt("basic_cnt", a.match_cnt, 8'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0, "basic_pulse_end");
      chk_cnt("basic_cnt_hold", a.match_cnt, 8'd1);

      // Overlapping: the trailing 0110 reuses the matched suffix.
      do_reset();
      chk_cnt("rst_before_ovl", a.match_cnt, 8'd0);
      word(6'b100110, 1'b1, 6'b000001, "ovl1_first");
      tail = 4'b0110; tail_exp = 4'b0001;
      for (int i = 3; i >= 0; i--) step(1'b1, tail[i], 1'b1, tail_exp[i], "ovl1_tail");
      chk_cnt("ovl1_cnt", a.match_cnt, 8'd2);

      // Non-overlapping: same stream yields one match only.
      do_reset();
      word(6'b100110, 1'b0, 6'b000001, "ovl0_first");
      tail = 4'b0110; tail_exp = 4'b0000;
      for (int i = 3; i >= 0; i--) step(1'b1, tail[i], 1'b0, tail_exp[i], "ovl0_tail");
      chk_cnt("ovl0_cnt", a.match_cnt, 8'd1);

      // Enable gaps: three unqualified random bits between every qualified bit.
      do_reset();
      begin
         logic [5:0] pw;
         pw = 6'b100110;
         for (int i = 5; i >= 0; i--) begin
            step(1'b1, pw[i], 1'b1, (i == 0), "gap_qual");
            for (int g = 0; g < 3; g++) begin
               step(1'b0, 1'($urandom_range(1, 0)), 1'b1, 1'b0, "gap_idle");
            end
         end
      end
      chk_cnt("gap_cnt", a.match_cnt, 8'd1);

      // Reset mid-sequence discards 10011; the following 0 must not complete it.
      do_reset();
      begin
         logic [4:0] pre;
         pre = 5'b10011;
         for (int i = 4; i >= 0; i--) step(1'b1, pre[i], 1'b1, 1'b0, "mid_pre");
      end
      do_reset();
      step(1'b1, 1'b0, 1'b1, 1'b0, "mid_after_rst");
      chk_cnt("mid_cnt0", a.match_cnt, 8'd0);
      word(6'b100110, 1'b1, 6'b000001, "mid_full");
      chk_cnt("mid_cnt1", a.match_cnt, 8'd1);

      // Counter saturation: five back-to-back patterns, non-overlapping.
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         word(6'b100110, 1'b0, 6'b000001, "sat_out");
         chk_bit("sat_out_narrow", b.out, 1'b1);
         chk_cnt("sat_cnt_wide",   a.match_cnt, 8'(k));
         chk_cnt("sat_cnt_narrow", {6'd0, b.match_cnt}, (k > 3) ? 8'd3 : 8'(k));
      end

`ifdef SEQDET_PROG_EN
      // Pattern write with a coincident sample: the sample is dropped, so seven 1s
      // are needed to see pulses after the 6th and 7th.
      do_reset();
      a.pat_we = 1'b1; a.pat_in = 6'b111111;
      step(1'b1, 1'b1, 1'b1, 1'b0, "prog_write");
      a.pat_we = 1'b0;
      chk_cnt("prog_cnt_hold", a.match_cnt, 8'd0);
      for (int i = 1; i <= 7; i++) step(1'b1, 1'b1, 1'b1, (i >= 6), "prog_ones");
      chk_cnt("prog_cnt", a.match_cnt, 8'd2);
      step(1'b0, 1'b1, 1'b1, 1'b0, "prog_pulse_end");
      // A rewrite clears progress but keeps the count.
      a.pat_we = 1'b1; a.pat_in = 6'b111111;
      step(1'b1, 1'b1, 1'b1, 1'b0, "prog_rewrite");
      a.pat_we = 1'b0;
      chk_cnt("prog_cnt_keep", a.match_cnt, 8'd2);
      for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, "prog_refill");
      step(1'b1, 1'b1, 1'b1, 1'b1, "prog_refill_hit");
      // Reset restores the default pattern.
      do_reset();
      word(6'b100110, 1'b1, 6'b000001, "prog_default_back");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
